// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Holds the PC, performs single-word
//            Wishbone-classic reads and hands {instruction, pc} to decode
//            through a valid/ready handshake. Redirects drop any fetch in
//            flight. Misaligned targets and bus errors are reported as
//            flagged packets in place of an instruction.
// Ports    : clk_i, rst_i            - clock, synchronous active-high reset
//            iport_*                 - Wishbone-classic read master
//            jump_i, jump_addr_i     - single-cycle redirect request/target
//            ready_i                 - decode accepts the current packet
//            valid_o, instruction_o,
//            pc_o                    - packet to decode
//            e_fetch_misaligned_o,
//            e_fetch_fault_o         - packet fault flags
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP        = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] iport_adr_o,
  output logic        iport_cyc_o,
  output logic        iport_stb_o,
  input  logic [31:0] iport_dat_i,
  input  logic        iport_ack_i,
  input  logic        iport_err_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        e_fetch_misaligned_o,
  output logic        e_fetch_fault_o
);

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        cyc_q, cyc_d;
  logic [31:0] adr_q, adr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        mis_q, mis_d;
  logic        fault_q, fault_d;

  // The open bus cycle terminates this clock (ack or err).
  logic        bus_done;
  logic        pc_misaligned;

  assign bus_done      = cyc_q & (iport_ack_i | iport_err_i);
  assign pc_misaligned = (pc_q[1:0] != 2'b00);

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_ADDR;
      cyc_q    <= 1'b0;
      adr_q    <= RESET_ADDR;
      valid_q  <= 1'b0;
      instr_q  <= NOP;
      pc_out_q <= 32'h0000_0000;
      mis_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cyc_q    <= cyc_d;
      adr_q    <= adr_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      mis_q    <= mis_d;
      fault_q  <= fault_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (jump_i) begin
          // A redirect with a cycle still pending must wait out that cycle.
          state_d = (cyc_q && !bus_done) ? S_DISCARD : S_FETCH;
        end else if (bus_done) begin
          state_d = S_HOLD;
        end else if (!cyc_q && pc_misaligned) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (jump_i || ready_i) begin
          state_d = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (bus_done) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d     = pc_q;
    cyc_d    = cyc_q;
    adr_d    = adr_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    mis_d    = mis_q;
    fault_d  = fault_q;

    case (state_q)
      S_FETCH: begin
        if (jump_i) begin
          pc_d    = jump_addr_i;
          valid_d = 1'b0;
          mis_d   = 1'b0;
          fault_d = 1'b0;
          if (bus_done) begin
            cyc_d = 1'b0;
          end
        end else if (cyc_q) begin
          if (iport_ack_i) begin
            cyc_d    = 1'b0;
            valid_d  = 1'b1;
            instr_d  = iport_dat_i;
            pc_out_d = adr_q;
            pc_d     = pc_q + 32'd4;
          end else if (iport_err_i) begin
            // PC stays put so the faulting address is what gets reported.
            cyc_d    = 1'b0;
            valid_d  = 1'b1;
            instr_d  = NOP;
            pc_out_d = adr_q;
            fault_d  = 1'b1;
          end
        end else if (pc_misaligned) begin
          // No bus cycle is issued for a misaligned target.
          valid_d  = 1'b1;
          instr_d  = NOP;
          pc_out_d = pc_q;
          mis_d    = 1'b1;
        end else begin
          cyc_d = 1'b1;
          adr_d = pc_q;
        end
      end
      S_HOLD: begin
        if (jump_i) begin
          pc_d    = jump_addr_i;
          valid_d = 1'b0;
          instr_d = NOP;
          mis_d   = 1'b0;
          fault_d = 1'b0;
        end else if (ready_i) begin
          valid_d = 1'b0;
          instr_d = NOP;
          mis_d   = 1'b0;
          fault_d = 1'b0;
        end
      end
      S_DISCARD: begin
        // The pending cycle's data is dropped; only the PC follows redirects.
        if (jump_i) begin
          pc_d = jump_addr_i;
        end
        if (bus_done) begin
          cyc_d = 1'b0;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign iport_adr_o          = adr_q;
  assign iport_cyc_o          = cyc_q;
  assign iport_stb_o          = cyc_q;
  assign valid_o              = valid_q;
  assign instruction_o        = instr_q;
  assign pc_o                 = pc_out_q;
  assign e_fetch_misaligned_o = mis_q;
  assign e_fetch_fault_o      = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A transaction-level model
//            predicts bus activity and packets each cycle; directed vectors
//            add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic        cyc;
  logic        stb;
  logic [31:0] dat;
  logic        ack;
  logic        err;
  logic        jump;
  logic [31:0] jaddr;
  logic        ready;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pco;
  logic        emis;
  logic        eflt;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .RESET_ADDR (32'h0000_0000),
    .NOP        (NOP)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .iport_adr_o          (adr),
    .iport_cyc_o          (cyc),
    .iport_stb_o          (stb),
    .iport_dat_i          (dat),
    .iport_ack_i          (ack),
    .iport_err_i          (err),
    .jump_i               (jump),
    .jump_addr_i          (jaddr),
    .ready_i              (ready),
    .valid_o              (valid),
    .instruction_o        (instr),
    .pc_o                 (pco),
    .e_fetch_misaligned_o (emis),
    .e_fetch_fault_o      (eflt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Instruction memory and Wishbone slave (acks after `lat` wait cycles)
  // --------------------------------------------------------------------------
  int   lat    = 0;
  int   wcnt   = 0;
  logic err_en = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0008: return 32'hDEAD_BEEF;
      32'h0000_0100: return 32'h00A0_0113;
      32'h0000_0200: return 32'h00C0_0193;
      default:       return {~a[15:0], a[15:0]};
    endcase
  endfunction

  always @(negedge clk) begin
    ack = 1'b0;
    err = 1'b0;
    dat = 32'h0;
    if (!cyc) begin
      wcnt = 0;
    end else if (wcnt >= lat) begin
      wcnt = 0;
      if (err_en && adr == 32'h20) err = 1'b1;
      else begin
        ack = 1'b1;
        dat = mem_word(adr);
      end
    end else begin
      wcnt++;
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: tracks bus cycle, discard, and held packet as plain flags
  // --------------------------------------------------------------------------
  logic        m_init = 1'b0;
  logic [31:0] m_pc;
  logic        m_cyc;
  logic [31:0] m_adr;
  logic        m_discard;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pco;
  logic        m_mis;
  logic        m_flt;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1; m_pc = 32'h0; m_cyc = 1'b0; m_adr = 32'h0; m_discard = 1'b0;
      m_valid = 1'b0; m_instr = NOP; m_pco = 32'h0; m_mis = 1'b0; m_flt = 1'b0;
    end else if (m_init) begin
      if (m_valid) begin
        if (jump) m_pc = jaddr;
        if (jump || ready) begin
          m_valid = 1'b0; m_mis = 1'b0; m_flt = 1'b0;
        end
      end else if (m_cyc) begin
        if (jump) m_pc = jaddr;
        if (ack || err) begin
          if (!m_discard && !jump) begin
            m_valid = 1'b1;
            m_pco   = m_adr;
            if (ack) begin
              m_instr = dat;
              m_pc    = m_adr + 32'd4;
            end else begin
              m_instr = NOP;
              m_flt   = 1'b1;
            end
          end
          m_cyc = 1'b0;
          m_discard = 1'b0;
        end else if (jump) begin
          m_discard = 1'b1;
        end
      end else begin
        if (jump) m_pc = jaddr;
        else if (m_pc[1:0] != 2'b00) begin
          m_valid = 1'b1; m_pco = m_pc; m_instr = NOP; m_mis = 1'b1;
        end else begin
          m_cyc = 1'b1; m_adr = m_pc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_valid", {31'b0, valid}, {31'b0, m_valid});
      chk("m_cyc", {31'b0, cyc}, {31'b0, m_cyc});
      chk("m_stb", {31'b0, stb}, {31'b0, m_cyc});
      if (m_cyc) chk("m_adr", adr, m_adr);
      chk("m_mis", {31'b0, emis}, {31'b0, m_valid & m_mis});
      chk("m_flt", {31'b0, eflt}, {31'b0, m_valid & m_flt});
      if (m_valid) begin
        chk("m_instr", instr, m_instr);
        chk("m_pco", pco, m_pco);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input string name);
    int n = 0;
    while (!cyc && n < 40) begin tick(); n++; end
    chk(name, {31'b0, cyc}, 32'd1);
  endtask

  task automatic wait_cyc_adr(input string name, input logic [31:0] a);
    int n = 0;
    while (!(cyc && adr == a) && n < 40) begin tick(); n++; end
    chk(name, adr, a);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid && n < 40) begin tick(); n++; end
    chk(name, {31'b0, valid}, 32'd1);
  endtask

  task automatic pulse_jump(input logic [31:0] a);
    jump = 1'b1; jaddr = a;
    tick();
    jump = 1'b0;
  endtask

  initial begin
    rst = 1'b1; jump = 1'b0; jaddr = 32'h0; ready = 1'b0;
    ack = 1'b0; err = 1'b0; dat = 32'h0;
    repeat (3) tick();
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_cyc", {31'b0, cyc}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pco", pco, 32'h0);
    chk("rst_flags", {30'b0, emis, eflt}, 32'd0);

    // First fetch, zero-wait ack
    rst = 1'b0;
    tick();
    chk("f1_cyc", {31'b0, cyc}, 32'd1);
    chk("f1_adr", adr, 32'h0);
    tick();
    chk("f1_valid", {31'b0, valid}, 32'd1);
    chk("f1_instr", instr, 32'h0050_0093);
    chk("f1_pco", pco, 32'h0);

    // Hold with ready low
    repeat (5) begin
      tick();
      chk("hold_valid", {31'b0, valid}, 32'd1);
      chk("hold_instr", instr, 32'h0050_0093);
      chk("hold_cyc", {31'b0, cyc}, 32'd0);
    end
    ready = 1'b1;
    tick();
    chk("acc_valid", {31'b0, valid}, 32'd0);
    tick();
    chk("f2_cyc", {31'b0, cyc}, 32'd1);
    chk("f2_adr", adr, 32'h4);

    // Redirect while the fetch at 0x8 is waiting; its data must be dropped
    lat = 3;
    wait_cyc_adr("wait_adr8", 32'h8);
    pulse_jump(32'h100);
    wait_cyc_adr("jmp_adr", 32'h100);
    wait_valid("jmp_valid");
    chk("jmp_pco", pco, 32'h100);
    chk("jmp_instr", instr, 32'h00A0_0113);

    // Redirect in the same cycle as ack
    lat = 0;
    wait_cyc("same_wait");
    pulse_jump(32'h200);
    chk("same_cyc", {31'b0, cyc}, 32'd0);
    chk("same_valid", {31'b0, valid}, 32'd0);
    tick();
    chk("same_adr", adr, 32'h200);
    chk("same_cyc2", {31'b0, cyc}, 32'd1);
    tick();
    chk("same_pco", pco, 32'h200);

    // Bus error at 0x20
    ready = 1'b0; err_en = 1'b1;
    pulse_jump(32'h20);
    wait_valid("err_valid");
    chk("err_flt", {31'b0, eflt}, 32'd1);
    chk("err_mis", {31'b0, emis}, 32'd0);
    chk("err_pco", pco, 32'h20);
    chk("err_instr", instr, NOP);
    repeat (3) tick();

    // Misaligned redirect
    err_en = 1'b0;
    pulse_jump(32'h102);
    chk("mis_drop", {31'b0, valid}, 32'd0);
    tick();
    chk("mis_valid", {31'b0, valid}, 32'd1);
    chk("mis_flag", {31'b0, emis}, 32'd1);
    chk("mis_flt", {31'b0, eflt}, 32'd0);
    chk("mis_pco", pco, 32'h102);
    chk("mis_instr", instr, NOP);
    chk("mis_cyc", {31'b0, cyc}, 32'd0);
    ready = 1'b1;
    tick();
    tick();
    chk("mis_again", {31'b0, emis}, 32'd1);
    chk("mis_nocyc", {31'b0, cyc}, 32'd0);

    // Reset in the middle of a bus cycle
    lat = 2;
    pulse_jump(32'h40);
    wait_cyc("rst_wait");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_cyc", {31'b0, cyc}, 32'd0);
    chk("mrst_valid", {31'b0, valid}, 32'd0);
    tick();
    chk("mrst_cyc2", {31'b0, cyc}, 32'd1);
    chk("mrst_adr", adr, 32'h0);

    // PC wrap at the top of the address space
    lat = 1;
    pulse_jump(32'hFFFF_FFFC);
    wait_cyc_adr("wrap_top", 32'hFFFF_FFFC);
    wait_valid("wrap_valid");
    chk("wrap_pco", pco, 32'hFFFF_FFFC);
    wait_cyc_adr("wrap_zero", 32'h0);

    // Mixed back-pressure and wait states, checked by the model
    for (int i = 0; i < 40; i++) begin
      ready = (i % 3 != 1);
      lat = i % 4;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the instruction decoder. Holds the PC, issues single-word Wishbone-classic reads on the instruction port, and presents {instruction, pc} to decode with a valid/ready handshake. Accepts one-cycle redirects from the execute/exception logic, discarding any fetch already in flight. Reports misaligned targets and bus errors as flagged packets instead of instructions.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
NOP, 32'h0000_0013, instruction word driven on instruction_o when no real instruction is held (addi x0,x0,0).

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, synchronous, active-high
iport_adr_o  out  32  Wishbone address, word aligned
iport_cyc_o  out  1  Wishbone cycle
iport_stb_o  out  1  Wishbone strobe (always equal to cyc)
iport_dat_i  in  32  Wishbone read data
iport_ack_i  in  1  Wishbone acknowledge
iport_err_i  in  1  Wishbone error
jump_i  in  1  redirect request, single-cycle pulse
jump_addr_i  in  32  redirect target, sampled when jump_i=1
ready_i  in  1  decode accepts the current packet
valid_o  out  1  packet valid
instruction_o  out  32  fetched word, to decoder instruction_i
pc_o  out  32  address of instruction_o
e_fetch_misaligned_o  out  1  packet is a misaligned-target fault
e_fetch_fault_o  out  1  packet is a bus-error fault

Behaviour:
- Reset (rst_i=1 at an edge): pc<=RESET_ADDR; state<=FETCH; cyc/stb<=0; valid_o<=0; instruction_o<=NOP; pc_o<=0; both e_* <=0. Reset overrides all other inputs, including mid-bus-cycle; the slave must tolerate cyc dropping without ack.
- All outputs are registered. The bus request is launched the cycle after entering FETCH: cyc/stb<=1, iport_adr_o<=pc. Address is held stable until ack or err.
- States: FETCH, HOLD, DISCARD.
- FETCH, ack=1, no jump: cyc/stb<=0; instruction_o<=iport_dat_i; pc_o<=iport_adr_o; valid_o<=1; pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0); go HOLD.
- FETCH, err=1, no jump: as ack, but instruction_o<=NOP, e_fetch_fault_o<=1, pc not incremented; go HOLD.
- HOLD: outputs stable while ready_i=0. On ready_i=1: valid_o<=0, e_* <=0; go FETCH (next request starts the following cycle). Minimum throughput: one instruction per 3 cycles with zero-wait-state ack.
- Redirect (jump_i=1, any state) has priority over ack/err/ready in the same cycle: pc<=jump_addr_i; valid_o<=0; e_* <=0; the current or arriving packet is dropped.
-- If the bus cycle is open and neither ack nor err arrives that cycle: go DISCARD. cyc/stb stay high at the old address.
-- Otherwise (no cycle open, or ack/err arrives the same cycle): cyc/stb<=0; go FETCH.
- DISCARD: wait for ack or err, drop the data, cyc/stb<=0, go FETCH. A further jump_i in DISCARD only updates pc.
- Misaligned target (pc[1:0]!=0 on entry to FETCH): no bus cycle. Next cycle: valid_o<=1, pc_o<=pc, instruction_o<=NOP, e_fetch_misaligned_o<=1; go HOLD; pc unchanged. Recovery requires jump_i.
- At most one outstanding bus transaction. At most one e_* flag is set. valid_o never drops without ready_i=1, jump_i=1 or reset.

Test Plan:
- Reset, RESET_ADDR=0, zero-wait ack with dat=0x00500093 -> first cycle has adr=0, cyc=1; then valid_o=1, instruction_o=0x00500093, pc_o=0; next fetch is at adr=4.
- ready_i=0 for 5 cycles with a packet held -> valid_o, instruction_o and pc_o stable, cyc=0; ready_i=1 -> valid_o=0 next cycle, then adr=4.
- jump_i to 0x100 while cyc=1 at adr 0x8, ack arrives 3 cycles later with dat=0xDEADBEEF -> that word is never presented; next request has adr=0x100; first packet has pc_o=0x100.
- jump_i the same cycle as ack -> data dropped, no DISCARD state; next adr=jump target.
- iport_err_i at adr 0x20 -> valid_o=1, e_fetch_fault_o=1, pc_o=0x20, instruction_o=0x00000013.
- jump_i to 0x102 -> no bus cycle; valid_o=1, e_fetch_misaligned_o=1, pc_o=0x102. Separately, rst_i asserted mid-bus-cycle -> cyc=0, valid_o=0 next edge; fetch restarts at RESET_ADDR.
